// File: rtl/rchdc_seq_ctrl.sv
// Job sequencer for the RCHDC classifier core: command intake, feature streaming, drain wait, response.
// Optional abort input is enabled by defining RCHDC_SEQ_CTRL_ABORT_EN.
module rchdc_seq_ctrl #(
  parameter int SMP_SIZE  = 16,
  parameter int SET_SIZE  = 8,
  parameter int CLS_DW    = 4,
  parameter int DRAIN_LAT = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_train,
  input  logic [CLS_DW-1:0]           cmd_label,
  input  logic                        feat_valid,
  output logic                        feat_ready,
  output logic [$clog2(SMP_SIZE)-1:0] feat_idx,
  output logic [$clog2(SET_SIZE)-1:0] smp_idx,
  output logic                        smp_en,
  output logic                        smp_clr,
  output logic                        set_clr,
  output logic                        state,
  output logic [CLS_DW-1:0]           label,
  input  logic [CLS_DW-1:0]           predict_in,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [CLS_DW-1:0]           rsp_class,
  output logic                        busy
`ifdef RCHDC_SEQ_CTRL_ABORT_EN
  ,
  input  logic                        abort
`endif
);

  localparam int FW = $clog2(SMP_SIZE);
  localparam int SW = $clog2(SET_SIZE);
  localparam int DW = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;
  localparam logic [FW-1:0] FEAT_LAST  = FW'(SMP_SIZE - 1);
  localparam logic [SW-1:0] SMP_LAST   = SW'(SET_SIZE - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_LAT - 1);

  // Core mode encoding: the core's `PREDICT is 0, training is 1.
  localparam logic STATE_PREDICT = 1'b0;
  localparam logic STATE_TRAIN   = 1'b1;

  // ABRT is the CLR-like cycle after an abort; it is unreachable unless the abort port exists.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    RESP   = 3'd4,
    ABRT   = 3'd5
  } fsm_t;

  fsm_t            fsm;
  logic            train_mode;
  logic [DW-1:0]   drain_cnt;
  logic            abort_hit;

`ifdef RCHDC_SEQ_CTRL_ABORT_EN
  assign abort_hit = abort && ((fsm == CLR) || (fsm == STREAM) || (fsm == DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  assign feat_ready = (fsm == STREAM);
  assign smp_en     = feat_ready && feat_valid;
  assign smp_clr    = (fsm == CLR) || (fsm == ABRT);
  assign set_clr    = smp_clr;
  assign rsp_valid  = (fsm == RESP);
  assign busy       = (fsm != IDLE);
  assign state      = train_mode ? STATE_TRAIN : STATE_PREDICT;

  // cmd_ready is a register so it stays low in the first cycle after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      cmd_ready  <= 1'b0;
      train_mode <= 1'b1;
      label      <= '0;
      feat_idx   <= '0;
      smp_idx    <= '0;
      drain_cnt  <= '0;
      rsp_class  <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            train_mode <= cmd_train;
            label      <= cmd_label;
            cmd_ready  <= 1'b0;
            fsm        <= CLR;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        CLR: begin
          feat_idx  <= '0;
          smp_idx   <= '0;
          drain_cnt <= '0;
          fsm       <= abort_hit ? ABRT : STREAM;
        end
        STREAM: begin
          if (abort_hit) begin
            fsm <= ABRT;
          end else if (feat_valid) begin
            if (feat_idx == FEAT_LAST) begin
              feat_idx <= '0;
              if (smp_idx == SMP_LAST) begin
                smp_idx   <= '0;
                drain_cnt <= DRAIN_LOAD;
                fsm       <= DRAIN;
              end else begin
                smp_idx <= smp_idx + SW'(1);
              end
            end else begin
              feat_idx <= feat_idx + FW'(1);
            end
          end
        end
        DRAIN: begin
          if (abort_hit) begin
            fsm <= ABRT;
          end else if (drain_cnt == '0) begin
            rsp_class <= train_mode ? '0 : predict_in;
            fsm       <= RESP;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            cmd_ready <= 1'b1;
            fsm       <= IDLE;
          end
        end
        ABRT: begin
          feat_idx  <= '0;
          smp_idx   <= '0;
          drain_cnt <= '0;
          cmd_ready <= 1'b1;
          fsm       <= IDLE;
        end
        default: begin
          cmd_ready <= 1'b0;
          fsm       <= IDLE;
        end
      endcase
    end
  end

endmodule
